pfb_deadlock_report_ctrl: RTL
=============================

Name: pfb_deadlock_report_ctrl

Overview:
Central controller for the per-process deadlock monitors of pfb_multichannel cosimulation. It collects the one-bit block flags from NUM_MON monitor instances and qualifies a deadlock only after the blocked set stays stable for THRESH cycles. It then reports each blocked process, round-robin, over a valid/ready report channel to the simulation reporter. It sits between the monitor array and the testbench reporter.

Parameters:
NUM_MON, 4, number of monitor block inputs (>=2)
THRESH, 16, consecutive stable-blocked cycles required to declare deadlock (>=2)
IDX_W, $clog2(NUM_MON), width of report index
CNT_W, $clog2(THRESH+1), qualify counter width

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
enable  in  1  detection enable; sampled each cycle
mon_block  in  NUM_MON  block flag per monitor instance (registered outputs of monitors)
all_idle  in  1  whole design idle (run finished); vetoes qualification
rpt_valid  out  1  report entry valid
rpt_ready  in  1  reporter accepts entry
rpt_idx  out  IDX_W  index of blocked monitor being reported
rpt_mask  out  NUM_MON  snapshot of blocked set at qualification
deadlock  out  1  sticky: a deadlock has been declared
rpt_count  out  16  number of accepted report entries, saturating at 16'hFFFF

Behaviour:
- Reset (async, reset_n=0): state=IDLE; qual_cnt=0; last_mask=0; snap=0; rr_ptr=0; rpt_valid=0; rpt_idx=0; rpt_mask=0; deadlock=0; rpt_count=0. Reset mid-report drops rpt_valid immediately; the entry is lost.
- States: IDLE, QUALIFY, SCAN, REPORT, HOLD.
- IDLE: if enable && !all_idle && mon_block!=0, latch last_mask=mon_block, set qual_cnt=1, go QUALIFY.
- QUALIFY, evaluated each cycle in this priority order:
  - !enable, all_idle, or mon_block==0: go IDLE, qual_cnt=0.
  - mon_block!=last_mask: last_mask=mon_block, qual_cnt=1, stay in QUALIFY (restart).
  - qual_cnt==THRESH-1: snap=mon_block, rpt_mask=mon_block, deadlock=1, go SCAN. Deadlock is declared exactly THRESH cycles after the first blocked sample.
  - Otherwise qual_cnt++.
- SCAN: one cycle. Select the first set bit of snap searching from rr_ptr upward with wrap at NUM_MON-1 -> 0. Register it into rpt_idx, set rpt_valid=1, go REPORT. snap is never 0 in SCAN.
- REPORT:
  - rpt_valid, rpt_idx and rpt_mask stay stable until rpt_ready.
  - On the cycle with rpt_valid && rpt_ready:
    - clear snap[rpt_idx];
    - rr_ptr = (rpt_idx+1) mod NUM_MON;
    - rpt_count++ (saturating);
    - rpt_valid=0 next cycle;
    - next state: SCAN if the remaining snap!=0, else HOLD.
  - rpt_ready while rpt_valid=0 is ignored.
  - enable and all_idle are ignored in SCAN/REPORT; a started report set always drains.
- HOLD: stay until mon_block==0 for one sampled cycle, then go IDLE. This prevents re-reporting the same stuck condition. deadlock stays 1.
- deadlock is cleared only by reset. rpt_mask holds its last snapshot until the next qualification.
- Latency: first rpt_valid is asserted THRESH+1 cycles after the first blocked sample (THRESH cycles qualifying plus 1 SCAN). Between accepted entries there is 1 SCAN cycle.
- Simultaneous events:
  - mon_block change on the same cycle qual_cnt reaches THRESH-1: restart wins.
  - all_idle together with a block in IDLE: stay in IDLE.

Decomposition:
- Shared package pfb_dbg_pkg: state enum (IDLE, QUALIFY, SCAN, REPORT, HOLD), the RPT_CNT_W=16 constant, and a function for the IDX_W/CNT_W computation.
- One sub-module: pfb_rr_pick. Combinational round-robin first-set-bit finder with inputs req[NUM_MON] and ptr[IDX_W], outputs idx[IDX_W] and found. It is instantiated in SCAN; the controller FSM and counters stay in the top.

Test Plan:
- THRESH=16, mon_block=4'b0010 held, rpt_ready=1 -> deadlock rises at cycle 16 after first sample; rpt_valid at cycle 17 with rpt_idx=1, rpt_mask=4'b0010; rpt_count=1; state HOLD until mon_block=0.
- mon_block=4'b0011 for 10 cycles, then 4'b0111 -> qualification restarts; deadlock rises 16 cycles after the change; entries are reported in order idx 0, 1, 2; rpt_count=3.
- Blocked 4'b1001 with all_idle pulsed at cycle 8 -> return to IDLE, deadlock=0, no rpt_valid; with all_idle held low throughout, the pattern qualifies.
- Backpressure: mask 4'b0110, rpt_ready=0 for 5 cycles -> rpt_valid/rpt_idx=1 stay stable for 5 cycles, accept, then idx=2; rr_ptr=3 afterwards. A second deadlock 4'b0011 then reports idx 0 first (wrap).
- reset_n asserted low mid-REPORT (asynchronous, between clock edges) -> rpt_valid, deadlock and rpt_count go to 0 immediately; after release, state is IDLE.
- enable=0 with mon_block=4'b1111 for 40 cycles -> no qualification; enable dropped during REPORT -> remaining entries still drain.

Source files
------------

// File: rtl/pfb_dbg_pkg.sv
// Shared types and helpers for the pfb deadlock report controller.
// Holds the FSM state encoding and width helpers.
package pfb_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    SCAN,
    REPORT,
    HOLD
  } state_t;

  localparam int RPT_CNT_W = 16;

  // Width of a field able to index n values; never below one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pfb_rr_pick.sv
// Round-robin first-set-bit finder.
// Searches req upward from ptr, wrapping at NUM_MON-1.
module pfb_rr_pick
  import pfb_dbg_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = clog2w(NUM_MON)
) (
  input  logic [NUM_MON-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  // Walk from farthest to nearest so the nearest set bit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_MON]) begin
        found = 1'b1;
        idx   = IDX_W'((int'(ptr) + i) % NUM_MON);
      end
    end
  end

endmodule

// File: rtl/pfb_deadlock_report_ctrl.sv
// Deadlock qualifier and round-robin reporter.
// Qualifies a stable blocked set, then drains it over valid/ready.
module pfb_deadlock_report_ctrl
  import pfb_dbg_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int THRESH  = 16,
  parameter int IDX_W   = clog2w(NUM_MON),
  parameter int CNT_W   = clog2w(THRESH + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [NUM_MON-1:0]   mon_block,
  input  logic                 all_idle,
  output logic                 rpt_valid,
  input  logic                 rpt_ready,
  output logic [IDX_W-1:0]     rpt_idx,
  output logic [NUM_MON-1:0]   rpt_mask,
  output logic                 deadlock,
  output logic [RPT_CNT_W-1:0] rpt_count
);

  state_t             state;
  logic [CNT_W-1:0]   qual_cnt;
  logic [NUM_MON-1:0] last_mask;
  logic [NUM_MON-1:0] snap;
  logic [NUM_MON-1:0] snap_left;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               accept;

  assign accept    = rpt_valid && rpt_ready;
  assign snap_left = snap & ~(NUM_MON'(1) << rpt_idx);

  pfb_rr_pick #(
    .NUM_MON (NUM_MON),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (snap),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Qualify, snapshot, and drain the blocked set one entry at a time.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      qual_cnt  <= '0;
      last_mask <= '0;
      snap      <= '0;
      rr_ptr    <= '0;
      rpt_valid <= 1'b0;
      rpt_idx   <= '0;
      rpt_mask  <= '0;
      deadlock  <= 1'b0;
      rpt_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable && !all_idle && |mon_block) begin
            last_mask <= mon_block;
            qual_cnt  <= CNT_W'(1);
            state     <= QUALIFY;
          end
        end
        QUALIFY: begin
          if (!enable || all_idle || mon_block == '0) begin
            qual_cnt <= '0;
            state    <= IDLE;
          end else if (mon_block != last_mask) begin
            last_mask <= mon_block;
            qual_cnt  <= CNT_W'(1);
          end else if (qual_cnt == CNT_W'(THRESH - 1)) begin
            snap     <= mon_block;
            rpt_mask <= mon_block;
            deadlock <= 1'b1;
            state    <= SCAN;
          end else begin
            qual_cnt <= qual_cnt + CNT_W'(1);
          end
        end
        SCAN: begin
          rpt_idx   <= pick_idx;
          rpt_valid <= pick_found;
          state     <= REPORT;
        end
        REPORT: begin
          if (accept) begin
            snap      <= snap_left;
            rr_ptr    <= (rpt_idx == IDX_W'(NUM_MON - 1)) ?
                         '0 : rpt_idx + IDX_W'(1);
            rpt_valid <= 1'b0;
            if (rpt_count != '1)
              rpt_count <= rpt_count + RPT_CNT_W'(1);
            state     <= (|snap_left) ? SCAN : HOLD;
          end
        end
        HOLD: begin
          if (mon_block == '0)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
